// File: rtl/alu_pipe_hs.sv
// alu_pipe_hs: parametrised ALU with a registered result/flag stage and
// valid/ready handshakes on the operand and result sides. Single-cycle ops
// stream at one result per cycle, including the same-edge drain+accept case.
// Optional feature macro: ALU_PIPE_MUL_EN
//   defined   -> opcode 1010 runs an iterative shift-add multiplier (WIDTH cycles)
//   undefined -> opcode 1010 is reported as illegal, no busy state exists
module alu_pipe_hs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             illegal_op
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

  // Add/subtract one bit wider so the top bit is carry-out / borrow.
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_illegal;
  logic             alu_is_mul;

  logic             accept;
  logic             mul_done;
  logic [WIDTH-1:0] mul_res;

  assign sum_w  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_w = {1'b0, op_a} - {1'b0, op_b};
  assign shamt  = op_b[SHW-1:0];
  assign accept = in_valid && in_ready;

  // Single-cycle datapath: decode opcode into result, carry, overflow, illegal.
  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise unlisted paths would hold their value and infer latches.
  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    alu_is_mul  = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
        alu_ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                    (sum_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_w[WIDTH-1:0];
        alu_carry = diff_w[WIDTH];
        alu_ovf   = (op_a[WIDTH-1] == ~op_b[WIDTH-1]) &&
                    (diff_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:  alu_is_mul = 1'b1;
`endif
      default: alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_step;
  logic             mul_start;

  // A MUL can only start from IDLE with the output register free or draining,
  // which is exactly when in_ready is high there.
  assign in_ready  = (state_q == S_IDLE) && (!out_valid || out_ready);
  assign mul_start = accept && alu_is_mul;
  // Only the low WIDTH bits of the product are kept, so the multiplicand can
  // simply shift left and drop its top bits.
  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_res   = acc_step;

  // FSM state register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and the completion strobe on the final step.
  always_comb begin
    state_d  = state_q;
    mul_done = 1'b0;
    case (state_q)
      S_IDLE: if (mul_start) state_d = S_MUL;
      S_MUL: begin
        if (cnt_q == CNT_LAST) begin
          mul_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  // Shift-add iteration: one partial product folded in per cycle.
  // NOTE: the partial-product registers are reset as well, so an aborted
  // multiply never leaves stale state behind for the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (mul_start) begin
      cnt_q    <= '0;
      mcand_q  <= op_a;
      mplier_q <= op_b;
      acc_q    <= '0;
    end else if (state_q == S_MUL) begin
      cnt_q    <= cnt_q + 1'b1;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_step;
    end
  end
`else
  // No internal busy state: readiness depends only on the output register.
  assign in_ready = !out_valid || out_ready;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
`endif

  // Output register: load on accept (or MUL completion), clear valid on drain.
  // A drain and an accept on the same edge simply reload, keeping out_valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_neg   <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      illegal_op <= 1'b0;
    end else if (accept && !alu_is_mul) begin
      out_valid  <= 1'b1;
      result     <= alu_res;
      flag_zero  <= (alu_res == '0);
      flag_neg   <= alu_res[WIDTH-1];
      flag_carry <= alu_carry;
      flag_ovf   <= alu_ovf;
      illegal_op <= alu_illegal;
    end else if (mul_done) begin
      out_valid  <= 1'b1;
      result     <= mul_res;
      flag_zero  <= (mul_res == '0);
      flag_neg   <= mul_res[WIDTH-1];
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      illegal_op <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// tb_alu_pipe_hs: self-checking bench for alu_pipe_hs at WIDTH=32.
// A scoreboard queue receives a model result for every accepted operation and
// is compared against every drained result. Directed steps cover reset,
// latency, backpressure, back-to-back streaming and the MUL/illegal path.
module tb_alu_pipe_hs;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       alu_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_zero;
  logic             flag_neg;
  logic             flag_carry;
  logic             flag_ovf;
  logic             illegal_op;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags;  // {zero, neg, carry, ovf, illegal}
    logic [3:0]  op;
  } exp_t;

  exp_t sb_q[$];

  alu_pipe_hs #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_ctrl   (alu_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_neg   (flag_neg),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] flags_obs();
    return {flag_zero, flag_neg, flag_carry, flag_ovf, illegal_op};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: independent formulation using wide signed arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t        e;
    logic [32:0] w;
    logic [63:0] p;
    longint      sr;
    int          sh;
    logic        carry;
    logic        ovf;
    logic        ill;
    logic [31:0] r;
    r = '0; carry = 1'b0; ovf = 1'b0; ill = 1'b0;
    sh = int'(b[4:0]);
    case (op)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0]; carry = w[32];
        sr = longint'($signed(a)) + longint'($signed(b));
        ovf = (sr != longint'($signed(r)));
      end
      4'd1: begin
        r = a - b; carry = (a < b);
        sr = longint'($signed(a)) - longint'($signed(b));
        ovf = (sr != longint'($signed(r)));
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      4'd8: for (int i = 0; i < 32; i++) r[i] = (i + sh > 31) ? a[31] : a[i + sh];
      4'd7: r = {31'd0, $signed(a) < $signed(b)};
      4'd9: r = {31'd0, a < b};
`ifdef ALU_PIPE_MUL_EN
      4'd10: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0];
      end
`endif
      default: ill = 1'b1;
    endcase
    e.res   = r;
    e.flags = {r == 32'd0, r[31], carry, ovf, ill};
    e.op    = op;
    return e;
  endfunction

  // Scoreboard monitor: sample between edges; compare drains, then record accepts.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      sb_q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_out++;
        checks++;
        assert (sb_q.size() > 0) else begin
          errors++;
          $error("FAIL sb_unexpected: observed result=%h with no pending expectation", result);
        end
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check($sformatf("sb_result_op%0h", e.op), result, e.res);
          check($sformatf("sb_flags_op%0h", e.op), flags_obs(), e.flags);
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) sb_q.push_back(model(op_a, op_b, alu_ctrl));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, wait (bounded) for acceptance, then withdraw.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int n;
    n = 0;
    in_valid = 1'b1; op_a = a; op_b = b; alu_ctrl = op;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("send_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res, input logic [4:0] fl);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_result"}, result, res);
    check({tag, "_flags"}, flags_obs(), fl);
  endtask

  // Safety net so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rops [8] = '{4'd2, 4'd3, 4'd4, 4'd6, 4'd5, 4'd1, 4'd0, 4'd9};
    logic [31:0] held;
    exp_t        e1;
    int          n0;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; alu_ctrl = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_flags", flags_obs(), 0);
    tick();
    reset = 1'b0;

    // Directed vectors, each checked one cycle after acceptance.
    send(32'h7FFF_FFFF, 32'h0000_0001, 4'd0); expect_out("add_ovf", 32'h8000_0000, 5'b01010);
    send(32'h0000_0001, 32'h0000_0002, 4'd1); expect_out("sub_borrow", 32'hFFFF_FFFF, 5'b01100);
    send(32'hFFFF_FFFF, 32'h0000_0001, 4'd7); expect_out("slt", 32'h0000_0001, 5'b00000);
    send(32'hFFFF_FFFF, 32'h0000_0001, 4'd9); expect_out("sltu", 32'h0000_0000, 5'b10000);
    send(32'h8000_0000, 32'h0000_0024, 4'd8); expect_out("sra", 32'hF800_0000, 5'b01000);
    send(32'h1234_5678, 32'h0000_0002, 4'd5); expect_out("sll", 32'h48D1_59E0, 5'b00000);
    send(32'hDEAD_BEEF, 32'h1234_5678, 4'd15); expect_out("illegal", 32'h0000_0000, 5'b10001);

    // Pseudo-random operands across the single-cycle ops.
    for (int i = 0; i < 8; i++) send($urandom, $urandom, rops[i]);
    tick();

    // Back-to-back: in_valid held high for four consecutive accepts.
    n0 = n_out;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; op_a = 32'h1000_0000 * (i + 1); op_b = 32'h0000_0F0F + i;
      alu_ctrl = (i % 2 == 0) ? 4'd0 : 4'd4;
      @(negedge clk);
      check($sformatf("b2b_ready_%0d", i), in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    check("b2b_count", n_out - n0, 4);

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    send(32'h0000_00F0, 32'h0000_0F00, 4'd3);
    e1 = model(32'h0000_00F0, 32'h0000_0F00, 4'd3);
    held = e1.res;
    in_valid = 1'b1; op_a = 32'h0000_0005; op_b = 32'h0000_0007; alu_ctrl = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready_%0d", i), in_ready, 0);
      check($sformatf("bp_valid_%0d", i), out_valid, 1);
      check($sformatf("bp_result_%0d", i), result, held);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    expect_out("bp_second", 32'hFFFF_FFFE, 5'b01100);

`ifdef ALU_PIPE_MUL_EN
    // Multiply: busy for WIDTH cycles, then the product appears.
    send(32'h0000_FFFF, 32'h0001_0001, 4'd10);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      check($sformatf("mul_busy_%0d", i), {out_valid, in_ready}, 2'b00);
    end
    expect_out("mul", 32'hFFFF_FFFF, 5'b01000);
    tick();

    // Reset in the middle of a multiply aborts it.
    send(32'h0000_0003, 32'h0000_0005, 4'd10);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mul_abort_valid", out_valid, 0);
    check("mul_abort_ready", in_ready, 1);
    check("mul_abort_result", result, 0);
    tick(); tick();
    check("mul_abort_quiet", out_valid, 0);
`else
    // Without the multiplier, 1010 is just another illegal opcode.
    send(32'h0000_FFFF, 32'h0001_0001, 4'd10);
    expect_out("mul_disabled", 32'h0000_0000, 5'b10001);
    tick();
`endif

    // Reset while a result is pending clears the output stage.
    out_ready = 1'b0;
    send(32'h0000_0005, 32'h0000_0003, 4'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_pend_valid", out_valid, 0);
    check("rst_pend_ready", in_ready, 1);
    check("rst_pend_result", result, 0);
    check("rst_pend_flags", flags_obs(), 0);

    tick(); tick();
    check("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
